// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: op encoding, NZCV flags and per-stage control payload.
package alu_pkg;

    localparam int unsigned CNTRL_W = 3;
    localparam int unsigned NZCV_W  = 4;

    typedef enum logic [CNTRL_W-1:0] {
        ALU_PASS_B   = 3'b000,
        ALU_SHL      = 3'b001,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110,
        ALU_SHR      = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Width-independent part of a stage payload; the result field is added per instance.
    typedef struct packed {
        flags_t flags;
        logic   illegal;
        logic   set_flags;
    } stage_ctl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands and op in, result, NZCV and illegal-op flag out.
// Shift ops 001/111 exist only when ALU_SHIFT_EN is defined; otherwise they decode as illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result_c,
    output flags_t           flags_c,
    output logic             illegal_c
);

    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] diff_c;
    logic           carry_c;
    logic           ovf_c;

    // Subtraction as A + ~B + 1 so the top bit is the no-borrow carry.
    assign sum_c  = {1'b0, a} + {1'b0, b};
    assign diff_c = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

`ifdef ALU_SHIFT_EN
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    logic [SHAMT_W-1:0] shamt_c;
    assign shamt_c = b[SHAMT_W-1:0];
`endif

    always_comb begin
        result_c  = '0;
        carry_c   = 1'b0;
        ovf_c     = 1'b0;
        illegal_c = 1'b0;
        case (op)
            ALU_PASS_B: result_c = b;
            ALU_ADD: begin
                result_c = sum_c[WIDTH-1:0];
                carry_c  = sum_c[WIDTH];
                ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUBTRACT: begin
                result_c = diff_c[WIDTH-1:0];
                carry_c  = diff_c[WIDTH];
                ovf_c    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_XOR: result_c = a ^ b;
`ifdef ALU_SHIFT_EN
            ALU_SHL: result_c = a << shamt_c;
            ALU_SHR: result_c = a >> shamt_c;
`endif
            default: illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        flags_c   = '0;
        flags_c.n = result_c[WIDTH-1];
        flags_c.z = (result_c == '0);
        flags_c.c = carry_c;
        flags_c.v = ovf_c;
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready on both sides, global stall and architectural NZCV register.
// Optional shift ops are enabled by defining ALU_SHIFT_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [CNTRL_W-1:0] cntrl,
    input  logic               set_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               negative,
    output logic               zero,
    output logic               overflow,
    output logic               carry_out,
    output logic               illegal,
    output logic [NZCV_W-1:0]  flags_q
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        stage_ctl_t       ctl;
    } stage_t;

    stage_t                 stage_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_vld_q;

    logic [WIDTH-1:0] core_result_c;
    flags_t           core_flags_c;
    logic             core_illegal_c;
    stage_t           stage_in_c;
    stage_t           head_c;
    logic             en_c;
    logic             accept_c;
    logic             retire_c;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (A),
        .b         (B),
        .op        (alu_op_t'(cntrl)),
        .result_c  (core_result_c),
        .flags_c   (core_flags_c),
        .illegal_c (core_illegal_c)
    );

    assign head_c    = stage_q[PIPE_STAGES-1];
    assign out_valid = stage_vld_q[PIPE_STAGES-1];

    // A held, unconsumed result freezes the whole pipe; bubbles are not squeezed out.
    assign en_c     = ~(out_valid & ~out_ready);
    assign in_ready = en_c;
    assign accept_c = in_valid & en_c;
    assign retire_c = out_valid & out_ready;

    always_comb begin
        stage_in_c = '0;
        if (accept_c) begin
            stage_in_c.result        = core_result_c;
            stage_in_c.ctl.flags     = core_flags_c;
            stage_in_c.ctl.illegal   = core_illegal_c;
            stage_in_c.ctl.set_flags = set_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_vld_q <= '0;
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_c) begin
            stage_vld_q[0] <= accept_c;
            stage_q[0]     <= stage_in_c;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                stage_vld_q[i] <= stage_vld_q[i-1];
                stage_q[i]     <= stage_q[i-1];
            end
        end
    end

    // Illegal ops never commit flags, whatever set_flags says.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
        end else if (retire_c && head_c.ctl.set_flags && !head_c.ctl.illegal) begin
            flags_q <= head_c.ctl.flags;
        end
    end

    assign result    = head_c.result;
    assign negative  = head_c.ctl.flags.n;
    assign zero      = head_c.ctl.flags.z;
    assign carry_out = head_c.ctl.flags.c;
    assign overflow  = head_c.ctl.flags.v;
    assign illegal   = head_c.ctl.illegal;

endmodule
